// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
//   Samples NUM_BTNS asynchronous push-button/switch pins. Each pin is
//   synchronized, then debounced against a shared 1 ms tick. Edges are
//   reported as one-cycle pulses and latched into sticky pending bits, which
//   feed a maskable, registered interrupt line.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   btn_in         raw asynchronous pin levels
//   btn_state      debounced level, 1 = pressed
//   btn_rise       one-cycle pulse on debounced 0->1
//   btn_fall       one-cycle pulse on debounced 1->0
//   event_pending  sticky edge flags (set beats clear)
//   event_clear    write-1-to-clear pulses, one per channel
//   irq_enable     per-channel interrupt mask
//   irq            registered OR of (event_pending & irq_enable)
// -----------------------------------------------------------------------------

// One debounce channel: synchronizer + tick-driven disagreement counter.
module button_reader_chan #(
   parameter int DEBOUNCE_MS = 10,
   parameter int SYNC_STAGES = 2,
   parameter int INVERT      = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_tick,
   input  logic i_pin,
   output logic o_state,
   output logic o_rise,
   output logic o_fall
);
   localparam int             CW      = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_MS - 1);
   localparam logic           POL     = (INVERT != 0);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_state;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync;

   // Polarity is applied after the last flop so the synchronizer itself
   // resets to 0 regardless of INVERT.
   assign w_sync = r_sync[SYNC_STAGES-1] ^ POL;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      end
   end

   // The counter tracks consecutive disagreeing ticks; any agreeing tick
   // restarts it. The edge pulses come from the same update that flips the
   // state, so they line up with the first cycle of the new level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_state <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (i_tick) begin
            if (w_sync == r_state) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
               r_state <= w_sync;
               r_cnt   <= '0;
               r_rise  <= w_sync;
               r_fall  <= ~w_sync;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign o_state = r_state;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
endmodule

module button_reader #(
   parameter int NUM_BTNS    = 4,
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int DEBOUNCE_MS = 10,
   parameter int SYNC_STAGES = 2,
   parameter int INVERT      = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_in,
   output logic [NUM_BTNS-1:0] btn_state,
   output logic [NUM_BTNS-1:0] btn_rise,
   output logic [NUM_BTNS-1:0] btn_fall,
   output logic [NUM_BTNS-1:0] event_pending,
   input  logic [NUM_BTNS-1:0] event_clear,
   input  logic [NUM_BTNS-1:0] irq_enable,
   output logic                irq
);
   localparam int            TICK_DIV = CLK_FREQ_HZ / 1000;
   localparam int            TW       = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   logic [TW-1:0]       r_tick_cnt;
   logic                w_tick;
   logic [NUM_BTNS-1:0] r_pend;
   logic                r_irq;

   // Shared 1 ms strobe; first strobe lands TICK_DIV cycles after reset.
   assign w_tick = (r_tick_cnt == TICK_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
      button_reader_chan #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .SYNC_STAGES (SYNC_STAGES),
         .INVERT      (INVERT)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .i_tick  (w_tick),
         .i_pin   (btn_in[g]),
         .o_state (btn_state[g]),
         .o_rise  (btn_rise[g]),
         .o_fall  (btn_fall[g])
      );
   end

   // A new edge takes priority over a simultaneous clear so no event is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~event_clear) | btn_rise | btn_fall;
         r_irq  <= |(r_pend & irq_enable);
      end
   end

   assign event_pending = r_pend;
   assign irq           = r_irq;
endmodule
